// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA scan-out has fixed priority and the CPU gets a forced
// slot after MAX_WAIT denied cycles. A pixel lost to a forced slot is replaced by the last one read.
module vram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       miss_cnt
);

  typedef enum logic {IDLE, ACK} state_e;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic              vga_valid_q, vga_hit_q, vga_miss_q, rd_q;
  logic [DATA_W-1:0] last_pix_q;
  logic [15:0]       miss_cnt_q;

  logic cpu_ok, forced, grant_cpu, grant_vga;

  assign cpu_ok    = cpu_req & (state_q == IDLE);
  assign forced    = cpu_ok & (wait_q == WAIT_MAX);
  assign grant_cpu = cpu_ok & (forced | ~vga_req);
  assign grant_vga = vga_req & ~grant_cpu;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_cpu) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (grant_vga) begin
      mem_en   = 1'b1;
      mem_addr = vga_addr;
    end
  end

  // ACK lasts exactly one cycle and blocks a re-grant of the still-held request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_cpu) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (grant_cpu || !cpu_req)        wait_d = '0;
    else if (cpu_ok && wait_q != WAIT_MAX) wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      vga_valid_q <= 1'b0;
      vga_hit_q   <= 1'b0;
      vga_miss_q  <= 1'b0;
      rd_q        <= 1'b0;
      last_pix_q  <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      vga_valid_q <= vga_req;
      vga_hit_q   <= grant_vga;
      vga_miss_q  <= vga_req & grant_cpu;
      rd_q        <= grant_cpu & ~cpu_we;
      if (vga_hit_q) last_pix_q <= mem_rdata;
      if (vga_req && grant_cpu && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  // Read data arrives from the RAM in the cycle after the grant, so it is steered, not stored.
  assign vga_valid = vga_valid_q;
  assign vga_miss  = vga_miss_q;
  assign vga_rdata = vga_hit_q ? mem_rdata : last_pix_q;
  assign cpu_ack   = (state_q == ACK);
  assign cpu_rdata = rd_q ? mem_rdata : '0;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM behind the mem_* port.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vga_req, vga_valid, vga_miss;
  logic [11:0] vga_addr;
  logic [7:0]  vga_rdata;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [15:0] miss_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(12), .DATA_W(8), .MAX_WAIT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid),
    .vga_rdata(vga_rdata), .vga_miss(vga_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .miss_cnt(miss_cnt)
  );

  // Unwritten words hold a known pattern so reads are checkable.
  function automatic logic [7:0] f(input logic [11:0] a);
    return a[7:0] ^ 8'hC3;
  endfunction

  bit [7:0] ram [4096];
  bit       wrb [4096];
  bit [7:0] ram_q;
  int       wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        wrb[mem_addr] <= 1'b1;
        if (rst_n) wr_cnt <= wr_cnt + 1;
      end else begin
        ram_q <= wrb[mem_addr] ? ram[mem_addr] : f(mem_addr);
      end
    end
  end
  assign mem_rdata = ram_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic creq, cwe; logic [11:0] caddr; logic [7:0] cwd;
    logic vreq; logic [11:0] vaddr;
    logic men, mwe; logic [11:0] maddr; logic [7:0] mwd;
    logic ack, vvalid; logic [7:0] crd, vrd;
  } vec_t;

  vec_t v [7];

  initial begin
    int gcyc, ack_at, miss_at, nmiss, w0, nack, bad;
    int ackc [4];
    logic [7:0]  mpix;
    logic [15:0] first_cnt;
    logic        acked;

    //        creq cwe caddr   cwd    vreq vaddr   men mwe maddr   mwd    ack vv crd    vrd
    v[0] = '{1'b0,1'b0,12'h000,8'h00,1'b0,12'h000,1'b0,1'b0,12'h000,8'h00,1'b0,1'b0,8'h00,8'h00};
    v[1] = '{1'b0,1'b0,12'h000,8'h00,1'b1,12'h010,1'b1,1'b0,12'h010,8'h00,1'b0,1'b1,8'h00,8'hD3};
    v[2] = '{1'b1,1'b1,12'h123,8'h5A,1'b0,12'h000,1'b1,1'b1,12'h123,8'h5A,1'b1,1'b0,8'h00,8'h00};
    v[3] = '{1'b1,1'b0,12'h123,8'hEE,1'b1,12'h010,1'b1,1'b0,12'h010,8'h00,1'b0,1'b1,8'h00,8'hD3};
    v[4] = '{1'b1,1'b0,12'h123,8'h11,1'b0,12'h000,1'b1,1'b0,12'h123,8'h11,1'b1,1'b0,8'h5A,8'h00};
    v[5] = '{1'b1,1'b1,12'hFFF,8'hFF,1'b0,12'h7FF,1'b1,1'b1,12'hFFF,8'hFF,1'b1,1'b0,8'h00,8'h00};
    v[6] = '{1'b0,1'b0,12'h000,8'h00,1'b1,12'hFFF,1'b1,1'b0,12'hFFF,8'h00,1'b0,1'b1,8'h00,8'hFF};

    rst_n = 1'b0; vga_req = 0; vga_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_vga_valid", vga_valid, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_mem_en", mem_en, 0);
    rst_n = 1'b1;

    // Single-cycle vectors: mem_* in the request cycle, registered results one cycle later.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cpu_req = v[i].creq; cpu_we = v[i].cwe; cpu_addr = v[i].caddr; cpu_wdata = v[i].cwd;
      vga_req = v[i].vreq; vga_addr = v[i].vaddr;
      #1;
      chk($sformatf("v%0d_mem_en", i), mem_en, v[i].men);
      chk($sformatf("v%0d_mem_we", i), mem_we, v[i].mwe);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, v[i].maddr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v[i].mwd);
      @(posedge clk); #1;
      cpu_req = 0; vga_req = 0;
      @(negedge clk);
      chk($sformatf("v%0d_cpu_ack", i), cpu_ack, v[i].ack);
      chk($sformatf("v%0d_vga_valid", i), vga_valid, v[i].vvalid);
      chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, v[i].crd);
      chk($sformatf("v%0d_vga_miss", i), vga_miss, 0);
      if (v[i].vvalid) chk($sformatf("v%0d_vga_rdata", i), vga_rdata, v[i].vrd);
      @(posedge clk);
    end

    // Scan-out: a pixel every cycle, no CPU traffic.
    @(posedge clk); #1;
    vga_req = 1; vga_addr = 12'h300;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk($sformatf("scan%0d_valid", k), vga_valid, 1);
        chk($sformatf("scan%0d_rdata", k), vga_rdata, f(12'h300 + 12'(k - 1)));
        chk($sformatf("scan%0d_miss", k), vga_miss, 0);
      end
      @(posedge clk); #1;
      vga_addr = vga_addr + 12'd1;
    end
    vga_req = 0;

    // Contention: CPU held against continuous scan-out gets the 17th cycle.
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h200; cpu_wdata = 8'h77;
    vga_req = 1; vga_addr = 12'h040;
    gcyc = 0; ack_at = 0; miss_at = 0; nmiss = 0; mpix = '0; acked = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_en && mem_we && gcyc == 0) gcyc = k;
      if (vga_miss) begin nmiss++; miss_at = k; mpix = vga_rdata; end
      if (cpu_ack) begin acked = 1; ack_at = k; end
      @(posedge clk); #1;
      vga_addr = vga_addr + 12'd1;
      if (acked) cpu_req = 0;
    end
    vga_req = 0;
    chk("cont_grant_cycle", gcyc, 17);
    chk("cont_ack_cycle", ack_at, 18);
    chk("cont_miss_count", nmiss, 1);
    chk("cont_miss_cycle", miss_at, 18);
    chk("cont_miss_pixel", mpix, f(12'h04F));
    chk("cont_miss_cnt", miss_cnt, 1);

    // Back-to-back CPU writes with cpu_req never dropped between them.
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h250; cpu_wdata = 8'hA0;
    w0 = wr_cnt; nack = 0; bad = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      acked = cpu_ack;
      if (cpu_ack) begin
        nack++;
        if (nack < 4) ackc[nack] = k;
        if (mem_en) bad++;
      end
      @(posedge clk); #1;
      if (acked) begin
        if (nack >= 3) cpu_req = 0;
        else begin cpu_addr = cpu_addr + 12'd1; cpu_wdata = cpu_wdata + 8'd1; end
      end
    end
    chk("b2b_acks", nack, 3);
    chk("b2b_ack1", ackc[1], 2);
    chk("b2b_ack2", ackc[2], 4);
    chk("b2b_ack3", ackc[3], 6);
    chk("b2b_grant_in_ack", bad, 0);
    chk("b2b_writes", wr_cnt - w0, 3);

    // Reset lands mid-write; the held request is served once after release.
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h0AB; cpu_wdata = 8'h3C;
    w0 = wr_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstw_cpu_ack", cpu_ack, 0);
    chk("rstw_vga_valid", vga_valid, 0);
    chk("rstw_vga_miss", vga_miss, 0);
    chk("rstw_miss_cnt", miss_cnt, 0);
    chk("rstw_cpu_rdata", cpu_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_ack_after", cpu_ack, 1);
    @(posedge clk); #1;
    cpu_req = 0;
    @(negedge clk);
    chk("rstw_ack_single", cpu_ack, 0);
    chk("rstw_writes", wr_cnt - w0, 1);

    // Saturation: start the counter just below full, then take five forced slots.
    @(negedge clk);
    force dut.miss_cnt_q = 16'hFFFD;
    #1;
    release dut.miss_cnt_q;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h3F0; cpu_wdata = 8'h00;
    vga_req = 1; vga_addr = 12'h100;
    nmiss = 0; first_cnt = '0;
    for (int k = 1; k <= 95; k++) begin
      @(negedge clk);
      if (vga_miss) begin
        nmiss++;
        if (nmiss == 1) first_cnt = miss_cnt;
      end
    end
    cpu_req = 0; vga_req = 0;
    chk("sat_misses", nmiss, 5);
    chk("sat_first", first_cnt, 16'hFFFE);
    chk("sat_hold", miss_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
